// File: rtl/tiger_lsu_pkg.sv
// Shared definitions for the Tiger Avalon load/store unit:
// access size encodings, FSM state type and the byteenable/lane helpers.
package tiger_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;  // 2'b11 is also treated as a word

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CMD  = 2'b01,
    RESP = 2'b10,
    DONE = 2'b11
  } lsu_state_t;

  // Byte lanes touched by an access; the address is forced aligned to its size.
  function automatic logic [3:0] lsu_byteenable(input logic [1:0] size,
                                                input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SZ_BYTE: be = 4'b0001 << addr_lo;
      SZ_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicate right-justified store data across every lane it could occupy.
  function automatic logic [31:0] lsu_replicate(input logic [1:0]  size,
                                                input logic [31:0] wdata);
    logic [31:0] wd;
    case (size)
      SZ_BYTE: wd = {4{wdata[7:0]}};
      SZ_HALF: wd = {2{wdata[15:0]}};
      default: wd = wdata;
    endcase
    return wd;
  endfunction

  // A half on an odd byte or a word off a 4-byte boundary.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/tiger_lsu_lane_align.sv
// Combinational load lane select: shifts the addressed byte/half down to
// bit 0 and sign- or zero-extends it to 32 bits.
module tiger_lsu_lane_align
  import tiger_lsu_pkg::*;
(
  input  logic [31:0] readdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic        fill;
  logic        is_byte;
  logic        is_half;

  assign is_byte = (size == SZ_BYTE);
  assign is_half = (size == SZ_HALF);

  // Move the addressed lane to the bottom; half ignores addr[0], word is unshifted.
  always_comb begin
    shifted = readdata;
    if (is_byte) begin
      shifted = readdata >> {addr_lo, 3'b000};
    end else if (is_half) begin
      shifted = readdata >> {addr_lo[1], 4'b0000};
    end
  end

  assign fill = is_signed & (is_byte ? shifted[7] : shifted[15]);

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_bit
      if (gi < 8) begin : g_lo
        assign result[gi] = shifted[gi];
      end else if (gi < 16) begin : g_mid
        assign result[gi] = is_byte ? fill : shifted[gi];
      end else begin : g_hi
        assign result[gi] = (is_byte | is_half) ? fill : shifted[gi];
      end
    end
  endgenerate

endmodule

// File: rtl/tiger_avalon_lsu.sv
// Tiger memory-stage load/store front end onto an Avalon-MM master.
// One request at a time; registered word-aligned command, lane-replicated
// writedata, lane-extracted/extended load result, pipeline stall until done.
// Optional build macro TIGER_LSU_MISALIGN_EN: adds misalign_err and completes
// misaligned half/word requests without a bus cycle.
module tiger_avalon_lsu
  import tiger_lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] req_address,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  output logic              stall,
  output logic [31:0]       rdata_out,
  output logic              rdata_valid,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest,
  input  logic              avm_readdatavalid
`ifdef TIGER_LSU_MISALIGN_EN
  ,
  output logic              misalign_err
`endif
);

  lsu_state_t        state_reg, state_next;
  logic              req_any;
  logic              misalign_hit;

  logic [1:0]        addr_lo_reg;
  logic [1:0]        size_reg;
  logic              signed_reg;
  logic              is_read_reg;
  logic [ADDR_W-1:0] avm_address_reg;
  logic [31:0]       avm_writedata_reg;
  logic [3:0]        avm_byteenable_reg;
  logic              avm_read_reg;
  logic              avm_write_reg;
  logic [31:0]       rdata_reg;
  logic [31:0]       load_result;

  assign req_any = req_read | req_write;

`ifdef TIGER_LSU_MISALIGN_EN
  logic misalign_reg;
  assign misalign_hit = lsu_misaligned(req_size, req_address[1:0]);
  assign misalign_err = (state_reg == DONE) & misalign_reg;
`else
  assign misalign_hit = 1'b0;
`endif

  tiger_lsu_lane_align u_lane_align (
    .readdata  (avm_readdata),
    .addr_lo   (addr_lo_reg),
    .size      (size_reg),
    .is_signed (signed_reg),
    .result    (load_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state: accept in IDLE, hand off on ~waitrequest, wait for the read data.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (req_any) state_next = misalign_hit ? DONE : CMD;
      CMD:  if (!avm_waitrequest) state_next = is_read_reg ? RESP : DONE;
      RESP: if (avm_readdatavalid) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch, registered Avalon command and load result capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_lo_reg        <= 2'b00;
      size_reg           <= SZ_BYTE;
      signed_reg         <= 1'b0;
      is_read_reg        <= 1'b0;
      avm_address_reg    <= '0;
      avm_writedata_reg  <= 32'h0;
      avm_byteenable_reg <= 4'h0;
      avm_read_reg       <= 1'b0;
      avm_write_reg      <= 1'b0;
      rdata_reg          <= 32'h0;
`ifdef TIGER_LSU_MISALIGN_EN
      misalign_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_any) begin
            addr_lo_reg <= req_address[1:0];
            size_reg    <= req_size;
            signed_reg  <= req_signed;
            is_read_reg <= req_read;
`ifdef TIGER_LSU_MISALIGN_EN
            misalign_reg <= misalign_hit;
`endif
            if (!misalign_hit) begin
              avm_address_reg    <= {req_address[ADDR_W-1:2], 2'b00};
              avm_byteenable_reg <= lsu_byteenable(req_size, req_address[1:0]);
              avm_writedata_reg  <= lsu_replicate(req_size, req_wdata);
              avm_read_reg       <= req_read;
              avm_write_reg      <= ~req_read;
            end
          end
        end
        CMD: begin
          if (!avm_waitrequest) begin
            avm_read_reg  <= 1'b0;
            avm_write_reg <= 1'b0;
          end
        end
        RESP: begin
          if (avm_readdatavalid) begin
            rdata_reg <= load_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign stall          = req_any & (state_reg != DONE);
  assign rdata_valid    = (state_reg == DONE);
  assign rdata_out      = rdata_reg;
  assign avm_address    = avm_address_reg;
  assign avm_read       = avm_read_reg;
  assign avm_write      = avm_write_reg;
  assign avm_writedata  = avm_writedata_reg;
  assign avm_byteenable = avm_byteenable_reg;

endmodule

// File: tb/tb_tiger_avalon_lsu.sv
// Directed self-checking bench for tiger_avalon_lsu.
module tb_tiger_avalon_lsu;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] req_address;
  logic        req_read;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_signed;
  logic        stall;
  logic [31:0] rdata_out;
  logic        rdata_valid;
  logic [31:0] avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        avm_readdatavalid;
`ifdef TIGER_LSU_MISALIGN_EN
  logic        misalign_err;
`endif

  tiger_avalon_lsu #(.ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .req_address       (req_address),
    .req_read          (req_read),
    .req_write         (req_write),
    .req_wdata         (req_wdata),
    .req_size          (req_size),
    .req_signed        (req_signed),
    .stall             (stall),
    .rdata_out         (rdata_out),
    .rdata_valid       (rdata_valid),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdatavalid (avm_readdatavalid)
`ifdef TIGER_LSU_MISALIGN_EN
    ,
    .misalign_err      (misalign_err)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Results gathered by do_access for the most recent request.
  int          res_stall;
  int          res_valid;
  int          res_cmds;
  logic [31:0] res_addr;
  logic [3:0]  res_be;
  logic [31:0] res_wd;
  logic        res_isw;
  logic        res_stable;
  logic        res_mis;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request and act as the Avalon slave: hold waitrequest for
  // 'waits' command cycles, return read data the cycle after acceptance.
  // Returns one cycle after the completion cycle with the request dropped.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [1:0] size, input logic sgn,
                           input logic [31:0] wdata, input int waits,
                           input logic [31:0] rdata);
    int  wait_left;
    int  cycles;
    bit  accepted;
    bit  done;
    bit  first;
    req_address = addr;
    req_read    = rd;
    req_write   = wr;
    req_size    = size;
    req_signed  = sgn;
    req_wdata   = wdata;
    avm_waitrequest = (waits > 0);
    wait_left  = waits;
    accepted   = 0;
    done       = 0;
    first      = 1;
    cycles     = 0;
    res_stall  = 0;
    res_valid  = 0;
    res_cmds   = 0;
    res_addr   = 32'h0;
    res_be     = 4'h0;
    res_wd     = 32'h0;
    res_isw    = 1'b0;
    res_stable = 1'b1;
    res_mis    = 1'b0;
    while (!done && cycles < 30) begin
      @(negedge clk);
      cycles++;
      if (stall) res_stall++;
      if (rdata_valid) res_valid++;
      if (avm_read || avm_write) begin
        if (first) begin
          res_addr = avm_address;
          res_be   = avm_byteenable;
          res_wd   = avm_writedata;
          res_isw  = avm_write;
          first    = 0;
        end else if (avm_address !== res_addr || avm_byteenable !== res_be ||
                     avm_writedata !== res_wd || avm_write !== res_isw) begin
          res_stable = 1'b0;
        end
        if (avm_waitrequest) begin
          wait_left--;
        end else begin
          res_cmds++;
          accepted = 1;
        end
      end
      if (!stall) begin
        done = 1;
`ifdef TIGER_LSU_MISALIGN_EN
        res_mis = misalign_err;
`endif
      end
      step();
      avm_readdatavalid = accepted && rd;
      avm_readdata      = (accepted && rd) ? rdata : 32'h0;
      accepted          = 0;
      avm_waitrequest   = (wait_left > 0);
    end
    if (!done) check_value("timeout", 32'd0, 32'd1);
    req_read  = 1'b0;
    req_write = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_waitrequest   = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req_address = 32'h0; req_read = 1'b0; req_write = 1'b0;
    req_wdata = 32'h0; req_size = 2'b00; req_signed = 1'b0;
    avm_readdata = 32'h0; avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0;
    step(); step();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check_value("rst_rdata_valid", {31'h0, rdata_valid}, 32'h0);
    check_value("rst_avm_rw", {30'h0, avm_read, avm_write}, 32'h0);
    check_value("rst_avm_address", avm_address, 32'h0);
    check_value("rst_be", {28'h0, avm_byteenable}, 32'h0);
    check_value("rst_wdata", avm_writedata, 32'h0);
    check_value("rst_rdata_out", rdata_out, 32'h0);
    check_value("rst_stall", {31'h0, stall}, 32'h0);
    step();

    // Byte store to 0x1003, no wait
    do_access(1'b0, 1'b1, 32'h0000_1003, 2'b00, 1'b0, 32'h0000_00A5, 0, 32'h0);
    $display("store byte  @1003: addr=%h be=%b wd=%h stall=%0d", res_addr, res_be, res_wd, res_stall);
    check_value("sb_addr", res_addr, 32'h0000_1000);
    check_value("sb_be", {28'h0, res_be}, 32'h8);
    check_value("sb_wd", res_wd, 32'hA5A5_A5A5);
    check_value("sb_is_write", {31'h0, res_isw}, 32'h1);
    check_value("sb_stall", res_stall, 32'd2);
    check_value("sb_valid", res_valid, 32'd1);
    check_value("sb_cmds", res_cmds, 32'd1);

    // Signed byte load from 0x2002
    do_access(1'b1, 1'b0, 32'h0000_2002, 2'b00, 1'b1, 32'h0, 0, 32'h0080_FF00);
    $display("load sbyte  @2002: rdata=%h stall=%0d", rdata_out, res_stall);
    check_value("lb_rdata", rdata_out, 32'hFFFF_FF80);
    check_value("lb_addr", res_addr, 32'h0000_2000);
    check_value("lb_be", {28'h0, res_be}, 32'h4);
    check_value("lb_stall", res_stall, 32'd3);
    check_value("lb_valid", res_valid, 32'd1);
    @(negedge clk);
    check_value("lb_valid_after", {31'h0, rdata_valid}, 32'h0);
    step();

    // Unsigned half load from 0x2002 with 3 waitrequest cycles
    do_access(1'b1, 1'b0, 32'h0000_2002, 2'b01, 1'b0, 32'h0, 3, 32'h8001_1234);
    $display("load uhalf  @2002: rdata=%h stall=%0d stable=%0d", rdata_out, res_stall, res_stable);
    check_value("lh_rdata", rdata_out, 32'h0000_8001);
    check_value("lh_stable", {31'h0, res_stable}, 32'h1);
    check_value("lh_be", {28'h0, res_be}, 32'hC);
    check_value("lh_stall", res_stall, 32'd6);
    check_value("lh_cmds", res_cmds, 32'd1);

    // Signed half load from 0x2000 (low lane)
    do_access(1'b1, 1'b0, 32'h0000_2000, 2'b01, 1'b1, 32'h0, 0, 32'h1234_8765);
    $display("load shalf  @2000: rdata=%h", rdata_out);
    check_value("lhs_rdata", rdata_out, 32'hFFFF_8765);
    check_value("lhs_be", {28'h0, res_be}, 32'h3);

    // Back-to-back word store then word load
    do_access(1'b0, 1'b1, 32'h0000_4000, 2'b10, 1'b0, 32'hDEAD_BEEF, 0, 32'h0);
    $display("store word  @4000: wd=%h be=%b cmds=%0d", res_wd, res_be, res_cmds);
    check_value("sw_wd", res_wd, 32'hDEAD_BEEF);
    check_value("sw_be", {28'h0, res_be}, 32'hF);
    check_value("sw_cmds", res_cmds, 32'd1);
    check_value("sw_rdata_kept", rdata_out, 32'hFFFF_8765);
    do_access(1'b1, 1'b0, 32'h0000_4004, 2'b11, 1'b0, 32'h0, 0, 32'h1234_5678);
    $display("load word   @4004: rdata=%h stall=%0d cmds=%0d", rdata_out, res_stall, res_cmds);
    check_value("lw_rdata", rdata_out, 32'h1234_5678);
    check_value("lw_addr", res_addr, 32'h0000_4004);
    check_value("lw_stall", res_stall, 32'd3);
    check_value("lw_cmds", res_cmds, 32'd1);

`ifdef TIGER_LSU_MISALIGN_EN
    // Misaligned word load: no bus cycle, error strobe with completion
    do_access(1'b1, 1'b0, 32'h0000_3001, 2'b10, 1'b0, 32'h0, 0, 32'hFFFF_FFFF);
    $display("load word   @3001: misalign=%0d cmds=%0d stall=%0d", res_mis, res_cmds, res_stall);
    check_value("mis_err", {31'h0, res_mis}, 32'h1);
    check_value("mis_cmds", res_cmds, 32'd0);
    check_value("mis_valid", res_valid, 32'd1);
    check_value("mis_stall", res_stall, 32'd1);
    check_value("mis_rdata_kept", rdata_out, 32'h1234_5678);
`else
    // Misaligned word store is forced aligned
    do_access(1'b0, 1'b1, 32'h0000_3003, 2'b10, 1'b0, 32'h1122_3344, 0, 32'h0);
    $display("store word  @3003: addr=%h be=%b wd=%h", res_addr, res_be, res_wd);
    check_value("fa_addr", res_addr, 32'h0000_3000);
    check_value("fa_be", {28'h0, res_be}, 32'hF);
    check_value("fa_wd", res_wd, 32'h1122_3344);
    check_value("fa_stall", res_stall, 32'd2);
    check_value("fa_rdata_kept", rdata_out, 32'h1234_5678);
`endif

    // Reset while in RESP, stale readdatavalid the next cycle
    req_address = 32'h0000_2000; req_size = 2'b10; req_signed = 1'b0;
    req_read = 1'b1; req_write = 1'b0; avm_waitrequest = 1'b0;
    step();                                   // CMD
    @(negedge clk);
    check_value("rr_cmd_read", {31'h0, avm_read}, 32'h1);
    step();                                   // RESP
    reset = 1'b1;
    @(negedge clk);
    check_value("rr_resp_stall", {31'h0, stall}, 32'h1);
    step();
    reset = 1'b0;
    req_read = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hCAFE_F00D;
    @(negedge clk);
    check_value("rr_valid", {31'h0, rdata_valid}, 32'h0);
    check_value("rr_avm_rw", {30'h0, avm_read, avm_write}, 32'h0);
    check_value("rr_addr", avm_address, 32'h0);
    check_value("rr_be", {28'h0, avm_byteenable}, 32'h0);
    check_value("rr_rdata", rdata_out, 32'h0);
    step();
    avm_readdatavalid = 1'b0;
    @(negedge clk);
    check_value("rr_valid2", {31'h0, rdata_valid}, 32'h0);
    check_value("rr_rdata2", rdata_out, 32'h0);
    $display("reset in RESP: rdata_valid=%0d rdata=%h", rdata_valid, rdata_out);
    step();

    // FSM back in IDLE: a fresh store completes normally
    do_access(1'b0, 1'b1, 32'h0000_5001, 2'b00, 1'b0, 32'h0000_003C, 0, 32'h0);
    $display("store byte  @5001: be=%b wd=%h stall=%0d", res_be, res_wd, res_stall);
    check_value("post_be", {28'h0, res_be}, 32'h2);
    check_value("post_wd", res_wd, 32'h3C3C_3C3C);
    check_value("post_stall", res_stall, 32'd2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
